// File: rtl/counter_enable_gen.sv
// Run/stop/single-step enable generator: debounced push buttons drive a small FSM
// that emits one-cycle count-enable pulses at a latched divide rate or one at a time.
module counter_enable_gen #(
    parameter int DB_CYCLES = 3,
    parameter int DIV_W     = 8
) (
    input  logic             Clk,
    input  logic             rst,
    input  logic             start_btn,
    input  logic             stop_btn,
    input  logic             step_btn,
    input  logic [DIV_W-1:0] div,
    output logic             en,
    output logic             running
);

    localparam int DBC_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DBC_W-1:0] DB_LAST = DBC_W'(DB_CYCLES - 1);

    localparam int P_START = 0;
    localparam int P_STOP  = 1;
    localparam int P_STEP  = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2
    } state_t;

    logic [2:0] w_btn_raw;
    logic [2:0] w_press;

    assign w_btn_raw = {step_btn, stop_btn, start_btn};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_btn
            logic             r_s1;
            logic             r_s2;
            logic             r_db;
            logic             r_db_d;
            logic             r_press;
            logic [DBC_W-1:0] r_db_cnt;

            // Level only follows s2 after it has disagreed for DB_CYCLES straight cycles.
            always_ff @(posedge Clk or negedge rst) begin
                if (!rst) begin
                    r_s1     <= 1'b0;
                    r_s2     <= 1'b0;
                    r_db     <= 1'b0;
                    r_db_d   <= 1'b0;
                    r_press  <= 1'b0;
                    r_db_cnt <= '0;
                end else begin
                    r_s1    <= w_btn_raw[gi];
                    r_s2    <= r_s1;
                    r_db_d  <= r_db;
                    r_press <= r_db & ~r_db_d;
                    if (r_s2 == r_db) begin
                        r_db_cnt <= '0;
                    end else if (r_db_cnt == DB_LAST) begin
                        r_db     <= r_s2;
                        r_db_cnt <= '0;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end
            end

            assign w_press[gi] = r_press;
        end
    endgenerate

    state_t           r_state;
    state_t           w_state_next;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_cnt_next;
    logic [DIV_W-1:0] r_div_l;
    logic [DIV_W-1:0] w_div_l_next;
    logic [DIV_W-1:0] w_div_eff;
    logic             r_en;
    logic             w_en_next;
    logic             r_running;

    assign w_div_eff = (div == '0) ? DIV_W'(1) : div;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_div_l_next = r_div_l;
        w_en_next    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_press[P_STOP]) begin
                    w_state_next = S_IDLE;
                end else if (w_press[P_STEP]) begin
                    w_state_next = S_STEP;
                    w_en_next    = 1'b1;
                end else if (w_press[P_START]) begin
                    w_state_next = S_RUN;
                    w_cnt_next   = '0;
                    w_div_l_next = w_div_eff;
                end
            end
            S_RUN: begin
                // Stop beats a coinciding terminal count, so no trailing pulse.
                if (w_press[P_STOP]) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end else if (r_cnt == r_div_l - 1'b1) begin
                    w_cnt_next = '0;
                    w_en_next  = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_STEP: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_div_l   <= DIV_W'(1);
            r_en      <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_div_l   <= w_div_l_next;
            r_en      <= w_en_next;
            r_running <= (w_state_next == S_RUN);
        end
    end

    assign en      = r_en;
    assign running = r_running;

endmodule

// File: tb/tb_counter_enable_gen.sv
// Directed-plus-random bench for counter_enable_gen against a timeline model that
// derives expected en/running from press times, divide ratios and modular arithmetic.
module tb_counter_enable_gen;

    localparam int DB   = 3;
    localparam int DW   = 8;
    localparam int LAT  = DB + 3;   // first sampling edge -> edge that consumes the press
    localparam int MAXC = 8192;
    localparam logic [2:0] B_START = 3'b001;
    localparam logic [2:0] B_STOP  = 3'b010;
    localparam logic [2:0] B_STEP  = 3'b100;

    logic          Clk = 1'b0;
    logic          rst;
    logic          start_btn;
    logic          stop_btn;
    logic          step_btn;
    logic [DW-1:0] div;
    logic          en;
    logic          running;

    counter_enable_gen #(.DB_CYCLES(DB), .DIV_W(DW)) dut (
        .Clk       (Clk),
        .rst       (rst),
        .start_btn (start_btn),
        .stop_btn  (stop_btn),
        .step_btn  (step_btn),
        .div       (div),
        .en        (en),
        .running   (running)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int acc_en   = 0;
    int acc_run  = 0;

    // Model: which buttons are consumed at which edge, plus the current run interval.
    logic [2:0] sched [0:MAXC-1];
    int   m_state;   // 0 idle, 1 run, 2 step
    int   m_rs;
    int   m_divl;
    logic m_en;
    logic m_run;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    endtask

    task automatic model_reset();
        m_state = 0;
        m_en    = 1'b0;
        m_run   = 1'b0;
        m_divl  = 1;
        m_rs    = 0;
        for (int i = 0; i < MAXC; i++) sched[i] = 3'b000;
    endtask

    task automatic model_edge();
        logic [2:0] a;
        a = (cyc < MAXC) ? sched[cyc] : 3'b000;
        case (m_state)
            0: begin
                m_en = 1'b0;
                if (a[1]) begin
                    m_state = 0;
                end else if (a[2]) begin
                    m_state = 2;
                    m_en    = 1'b1;
                end else if (a[0]) begin
                    m_state = 1;
                    m_rs    = cyc;
                    m_divl  = (div == 0) ? 1 : int'(div);
                end
            end
            1: begin
                if (a[1]) begin
                    m_state = 0;
                    m_en    = 1'b0;
                end else begin
                    m_en = (((cyc - m_rs) % m_divl) == 0);
                end
            end
            default: begin
                m_state = 0;
                m_en    = 1'b0;
            end
        endcase
        m_run = (m_state == 1);
    endtask

    task automatic tick();
        @(posedge Clk);
        cyc++;
        if (!rst) model_reset();
        else model_edge();
        #1;
        chk("en", en, m_en);
        chk("running", running, m_run);
        acc_en  += int'(en);
        acc_run += int'(running);
    endtask

    task automatic press_begin(input logic [2:0] mask);
        if (mask[0]) start_btn = 1'b1;
        if (mask[1]) stop_btn  = 1'b1;
        if (mask[2]) step_btn  = 1'b1;
        if (cyc + 1 + LAT < MAXC) sched[cyc + 1 + LAT] = sched[cyc + 1 + LAT] | mask;
    endtask

    task automatic release_btns();
        start_btn = 1'b0;
        stop_btn  = 1'b0;
        step_btn  = 1'b0;
    endtask

    task automatic press(input logic [2:0] mask);
        press_begin(mask);
        repeat ($urandom_range(DB, DB + 5)) tick();
        release_btns();
        repeat (10) tick();
    endtask

    task automatic start_run(input int d);
        div = DW'(d);
        press_begin(B_START);
        repeat (LAT + 1) tick();
        release_btns();
        chk("run_rise", running, 1);
    endtask

    task automatic glitch(input logic [2:0] mask, input int w);
        if (mask[0]) start_btn = 1'b1;
        if (mask[1]) stop_btn  = 1'b1;
        if (mask[2]) step_btn  = 1'b1;
        repeat (w) tick();
        release_btns();
        repeat (10) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d observed=timeout expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int a_edge;
        int op;
        rst = 1'b1;
        div = 8'd4;
        release_btns();
        model_reset();
        #2 rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        repeat (2) tick();

        // Start at div=4: rise 6 edges after first sample, 10 pulses per 40 cycles.
        div = 8'd4;
        press_begin(B_START);
        repeat (LAT) tick();
        chk("pre_rise", running, 0);
        tick();
        chk("run_rise", running, 1);
        release_btns();
        div = DW'($urandom_range(0, 255));
        acc_en = 0;
        repeat (40) tick();
        chk("div4_pulses", acc_en, 10);
        press(B_STOP);
        chk("stopped", running, 0);

        // Three single steps from IDLE.
        acc_en = 0;
        acc_run = 0;
        repeat (3) press(B_STEP);
        chk("step_pulses", acc_en, 3);
        chk("step_running", acc_run, 0);

        // div=0 behaves as 1: en continuously high.
        start_run(0);
        repeat (3) tick();
        acc_en = 0;
        repeat (10) tick();
        chk("div0_en", acc_en, 10);
        press(B_STOP);
        acc_en = 0;
        repeat (5) tick();
        chk("div0_after_stop", acc_en, 0);

        // Stop landing on a terminal count suppresses the pulse.
        start_run(5);
        k = 0;
        while (((cyc + 1 + LAT - m_rs) % 5) != 0 && k < 10) begin
            tick();
            k++;
        end
        a_edge = cyc + 1 + LAT;
        press_begin(B_STOP);
        while (cyc < a_edge) tick();
        chk("stop_tc_en", en, 0);
        chk("stop_tc_running", running, 0);
        release_btns();
        repeat (10) tick();
        start_run(2);
        acc_en = 0;
        repeat (12) tick();
        chk("div2_pulses", acc_en, 6);
        press(B_STOP);

        // Glitch and simultaneous-press priority.
        glitch(B_START, DB - 1);
        chk("glitch_idle", running, 0);
        press(B_START | B_STOP);
        chk("stop_beats_start", running, 0);
        acc_en = 0;
        press(B_STEP | B_START);
        chk("step_beats_start_en", acc_en, 1);
        chk("step_beats_start_run", running, 0);

        // Asynchronous reset in the middle of an en pulse, start held through release.
        start_run(int'($urandom_range(2, 6)));
        k = 0;
        while (!m_en && k < 20) begin
            tick();
            k++;
        end
        chk("pre_rst_en", en, 1);
        start_btn = 1'b1;
        rst = 1'b0;
        #1;
        chk("rst_en", en, 0);
        chk("rst_running", running, 0);
        chk("rst_cnt", dut.r_cnt, 0);
        model_reset();
        repeat (2) tick();
        rst = 1'b1;
        sched[cyc + 1 + LAT] = B_START;
        repeat (LAT + 1) tick();
        chk("held_start_run", running, 1);
        release_btns();
        repeat (15) tick();
        press(B_STOP);

        // Random mix of runs, steps and glitches.
        for (int i = 0; i < 6; i++) begin
            op = int'($urandom_range(0, 2));
            case (op)
                0: begin
                    start_run(int'($urandom_range(0, 9)));
                    repeat ($urandom_range(5, 30)) tick();
                    div = DW'($urandom_range(0, 255));
                    press(B_STOP);
                end
                1: press(B_STEP);
                default: glitch(3'b001 << $urandom_range(0, 2), int'($urandom_range(1, DB - 1)));
            endcase
        end
        chk("final_idle", running, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
